// File: rtl/round_ctrl.sv
// round_ctrl -- whack-a-mole round sequencer.
//
// Runs the game round: IDLE -> READY (countdown) -> PLAY (timed, scoring)
// -> DONE (result held, record block notified). Time and score are kept
// directly in two-digit BCD so they can drive displays without conversion.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_rst              synchronous active-high reset
//   i_start            one-cycle pulse, start a round (IDLE/DONE only)
//   i_hit              one-cycle pulse, one successful whack (PLAY only)
//   i_best1/i_best0    current high score, BCD tens/units
//   o_state            00 IDLE, 01 READY, 10 PLAY, 11 DONE
//   o_time1/o_time0    remaining seconds, BCD
//   o_score1/o_score0  current score, BCD
//   o_rec_we           one-cycle pulse on the first DONE cycle
//   o_new_best         high in DONE if the final score beat the best
//   o_mole_en          high while in PLAY
module round_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int ROUND_SEC = 30,
    parameter int READY_SEC = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_hit,
    input  logic [3:0] i_best1,
    input  logic [3:0] i_best0,
    output logic [1:0] o_state,
    output logic [3:0] o_time1,
    output logic [3:0] o_time0,
    output logic [3:0] o_score1,
    output logic [3:0] o_score0,
    output logic       o_rec_we,
    output logic       o_new_best,
    output logic       o_mole_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READY = 2'b01,
        S_PLAY  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam int             CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]     RDY0      = 4'(READY_SEC);
    localparam logic [3:0]     RND1      = 4'(ROUND_SEC / 10);
    localparam logic [3:0]     RND0      = 4'(ROUND_SEC % 10);

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_tcnt, w_tcnt_nx;
    logic [3:0]    r_time1, r_time0, w_time1_nx, w_time0_nx;
    logic [3:0]    r_score1, r_score0, w_score1_nx, w_score0_nx;
    logic          r_rec_we, w_rec_we_nx;
    logic          r_new_best, w_new_best_nx;

    logic          w_run, w_tick, w_time_one;
    logic [3:0]    w_dec1, w_dec0, w_inc1, w_inc0;

    // BCD decrement of remaining time (never applied at 00: the round ends at 01)
    always_comb begin
        w_dec1 = r_time1;
        w_dec0 = r_time0 - 4'd1;
        if (r_time0 == 4'd0) begin
            w_dec1 = r_time1 - 4'd1;
            w_dec0 = 4'd9;
        end
    end

    // BCD increment of score, saturating at 99
    always_comb begin
        w_inc1 = r_score1;
        w_inc0 = r_score0 + 4'd1;
        if (r_score1 == 4'd9 && r_score0 == 4'd9) begin
            w_inc1 = r_score1;
            w_inc0 = r_score0;
        end else if (r_score0 == 4'd9) begin
            w_inc1 = r_score1 + 4'd1;
            w_inc0 = 4'd0;
        end
    end

    assign w_run      = (r_state == S_READY) || (r_state == S_PLAY);
    assign w_tick     = w_run && (r_tcnt == TICK_LAST);
    assign w_time_one = (r_time1 == 4'd0) && (r_time0 == 4'd1);

    always_comb begin
        w_state_nx    = r_state;
        w_time1_nx    = r_time1;
        w_time0_nx    = r_time0;
        w_score1_nx   = r_score1;
        w_score0_nx   = r_score0;
        w_rec_we_nx   = 1'b0;
        w_new_best_nx = r_new_best;
        w_tcnt_nx     = '0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nx    = S_READY;
                    w_time1_nx    = 4'd0;
                    w_time0_nx    = RDY0;
                    w_score1_nx   = 4'd0;
                    w_score0_nx   = 4'd0;
                    w_new_best_nx = 1'b0;
                end
            end
            S_READY: begin
                if (w_tick) begin
                    if (w_time_one) begin
                        w_state_nx = S_PLAY;
                        w_time1_nx = RND1;
                        w_time0_nx = RND0;
                    end else begin
                        w_time1_nx = w_dec1;
                        w_time0_nx = w_dec0;
                    end
                end
            end
            S_PLAY: begin
                if (i_hit) begin
                    w_score1_nx = w_inc1;
                    w_score0_nx = w_inc0;
                end
                if (w_tick) begin
                    if (w_time_one) begin
                        // final tick: a coincident hit is already in w_score*_nx,
                        // so the committed and compared score includes it
                        w_state_nx    = S_DONE;
                        w_time1_nx    = 4'd0;
                        w_time0_nx    = 4'd0;
                        w_rec_we_nx   = 1'b1;
                        w_new_best_nx = {w_score1_nx, w_score0_nx} > {i_best1, i_best0};
                    end else begin
                        w_time1_nx = w_dec1;
                        w_time0_nx = w_dec0;
                    end
                end
            end
            default: ;
        endcase

        // tick divider restarts from 0 on any state change and idles outside READY/PLAY
        if (w_run && (w_state_nx == r_state) && !w_tick)
            w_tcnt_nx = r_tcnt + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tcnt     <= '0;
            r_time1    <= 4'd0;
            r_time0    <= 4'd0;
            r_score1   <= 4'd0;
            r_score0   <= 4'd0;
            r_rec_we   <= 1'b0;
            r_new_best <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_tcnt     <= w_tcnt_nx;
            r_time1    <= w_time1_nx;
            r_time0    <= w_time0_nx;
            r_score1   <= w_score1_nx;
            r_score0   <= w_score0_nx;
            r_rec_we   <= w_rec_we_nx;
            r_new_best <= w_new_best_nx;
        end
    end

    assign o_state    = r_state;
    assign o_time1    = r_time1;
    assign o_time0    = r_time0;
    assign o_score1   = r_score1;
    assign o_score0   = r_score0;
    assign o_rec_we   = r_rec_we;
    assign o_new_best = r_new_best;
    assign o_mole_en  = (r_state == S_PLAY);

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl -- directed self-checking bench for round_ctrl.
// Main instance: TICK_DIV=4, ROUND_SEC=12, READY_SEC=3.
// Second instance with ROUND_SEC=30 gives a round long enough to reach 99.
module tb_round_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, hit, rst2, start2, hit2;
    logic [3:0] best1, best0;

    logic [1:0] state, state2;
    logic [3:0] time1, time0, score1, score0;
    logic [3:0] time1_2, time0_2, score1_2, score0_2;
    logic       rec_we, new_best, mole_en;
    logic       rec_we2, new_best2, mole_en2;

    int checks = 0;
    int errors = 0;
    logic seen;

    always #5 clk = ~clk;

    round_ctrl #(.TICK_DIV(4), .ROUND_SEC(12), .READY_SEC(3)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_hit(hit),
        .i_best1(best1), .i_best0(best0),
        .o_state(state), .o_time1(time1), .o_time0(time0),
        .o_score1(score1), .o_score0(score0),
        .o_rec_we(rec_we), .o_new_best(new_best), .o_mole_en(mole_en)
    );

    round_ctrl #(.TICK_DIV(4), .ROUND_SEC(30), .READY_SEC(3)) u_sat (
        .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_hit(hit2),
        .i_best1(best1), .i_best0(best0),
        .o_state(state2), .o_time1(time1_2), .o_time0(time0_2),
        .o_score1(score1_2), .o_score0(score0_2),
        .o_rec_we(rec_we2), .o_new_best(new_best2), .o_mole_en(mole_en2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; hit = 1'b1;
        rst2 = 1'b1; start2 = 1'b0; hit2 = 1'b0;
        best1 = 4'd0; best0 = 4'd5;
        seen = 1'b0;
        step(); step();
        // reset beats start/hit
        check("rst_state",    8'(state), 8'h00);
        check("rst_time",     {time1, time0}, 8'h00);
        check("rst_score",    {score1, score0}, 8'h00);
        check("rst_recwe",    8'(rec_we), 8'h00);
        check("rst_newbest",  8'(new_best), 8'h00);
        check("rst_mole",     8'(mole_en), 8'h00);
        check("rst_state2",   8'(state2), 8'h00);

        rst = 1'b0; rst2 = 1'b0; start = 1'b0; hit = 1'b0;
        step();
        hit = 1'b1; step(); hit = 1'b0;
        check("idle_hit_score", {score1, score0}, 8'h00);
        check("idle_hit_state", 8'(state), 8'h00);

        // round 1: start -> READY
        start = 1'b1; step(); start = 1'b0;
        check("ready_state", 8'(state), 8'h01);
        check("ready_time",  {time1, time0}, 8'h03);
        check("ready_mole",  8'(mole_en), 8'h00);
        hit = 1'b1; step(); hit = 1'b0;        // ignored in READY
        start = 1'b1; step(); start = 1'b0;    // ignored in READY
        step();
        check("ready_hold_state", 8'(state), 8'h01);
        check("ready_hold_time",  {time1, time0}, 8'h03);
        check("ready_hit_score",  {score1, score0}, 8'h00);
        step();
        check("ready_tick1", {time1, time0}, 8'h02);
        repeat (8) step();
        check("play_state", 8'(state), 8'h02);
        check("play_time",  {time1, time0}, 8'h12);
        check("play_mole",  8'(mole_en), 8'h01);
        check("play_score", {score1, score0}, 8'h00);

        // PLAY: 5 hits
        hit = 1'b1; repeat (5) step(); hit = 1'b0;
        check("hits5_score", {score1, score0}, 8'h05);
        check("hits5_time",  {time1, time0}, 8'h11);
        repeat (6) step();
        check("time10", {time1, time0}, 8'h10);
        step();
        check("time09_borrow", {time1, time0}, 8'h09);
        hit = 1'b1; repeat (2) step(); hit = 1'b0;
        check("hits7_score", {score1, score0}, 8'h07);
        repeat (33) step();
        check("last_play_state", 8'(state), 8'h02);
        check("last_play_time",  {time1, time0}, 8'h01);
        check("last_play_recwe", 8'(rec_we), 8'h00);
        step();
        check("done_state",   8'(state), 8'h03);
        check("done_time",    {time1, time0}, 8'h00);
        check("done_recwe",   8'(rec_we), 8'h01);
        check("done_newbest", 8'(new_best), 8'h01);
        check("done_mole",    8'(mole_en), 8'h00);
        check("done_score",   {score1, score0}, 8'h07);
        hit = 1'b1; step(); hit = 1'b0;
        check("done_recwe_drop",  8'(rec_we), 8'h00);
        check("done_hit_score",   {score1, score0}, 8'h07);
        check("done_hold_state",  8'(state), 8'h03);
        check("done_newbest_hold", 8'(new_best), 8'h01);

        // restart from DONE
        start = 1'b1; step(); start = 1'b0;
        check("restart_state",   8'(state), 8'h01);
        check("restart_score",   {score1, score0}, 8'h00);
        check("restart_newbest", 8'(new_best), 8'h00);
        check("restart_time",    {time1, time0}, 8'h03);

        // round 2: final score 05 equals best 05, last hit on final tick
        repeat (12) step();
        check("r2_play", 8'(state), 8'h02);
        hit = 1'b1; repeat (4) step(); hit = 1'b0;
        repeat (43) step();
        check("r2_pre_score", {score1, score0}, 8'h04);
        hit = 1'b1; step(); hit = 1'b0;
        check("r2_done_state",   8'(state), 8'h03);
        check("r2_done_score",   {score1, score0}, 8'h05);
        check("r2_done_recwe",   8'(rec_we), 8'h01);
        check("r2_done_newbest", 8'(new_best), 8'h00);
        step();
        check("r2_recwe_drop", 8'(rec_we), 8'h00);

        // round 3: reset mid-PLAY at time 07, score 04
        start = 1'b1; step(); start = 1'b0;
        repeat (12) step();
        hit = 1'b1; repeat (4) step(); hit = 1'b0;
        repeat (17) step();
        check("r3_time",  {time1, time0}, 8'h07);
        check("r3_score", {score1, score0}, 8'h04);
        check("r3_state", 8'(state), 8'h02);
        rst = 1'b1; start = 1'b1; hit = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; hit = 1'b0;
        check("abort_state", 8'(state), 8'h00);
        check("abort_time",  {time1, time0}, 8'h00);
        check("abort_score", {score1, score0}, 8'h00);
        check("abort_mole",  8'(mole_en), 8'h00);
        if (rec_we) seen = 1'b1;
        repeat (60) begin
            step();
            if (rec_we) seen = 1'b1;
        end
        check("abort_no_recwe", 8'(seen), 8'h00);
        check("abort_idle", 8'(state), 8'h00);

        // saturation on the long-round instance
        start2 = 1'b1; step(); start2 = 1'b0;
        repeat (12) step();
        check("sat_play", 8'(state2), 8'h02);
        check("sat_time", {time1_2, time0_2}, 8'h30);
        hit2 = 1'b1;
        repeat (9) step();
        check("sat_09", {score1_2, score0_2}, 8'h09);
        step();
        check("sat_carry10", {score1_2, score0_2}, 8'h10);
        repeat (89) step();
        check("sat_99", {score1_2, score0_2}, 8'h99);
        repeat (3) step();
        hit2 = 1'b0;
        check("sat_99_hold", {score1_2, score0_2}, 8'h99);
        check("sat_still_play", 8'(state2), 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 50000000, clk cycles per one-second game tick (>=2).
REQ-002 Parameter: ROUND_SEC, default 30, round length in seconds, 1..99.
REQ-003 Parameter: READY_SEC, default 3, pre-round countdown in seconds, 1..9.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 start  in  1  one-cycle pulse, requests a new round.
REQ-007 hit  in  1  one-cycle pulse, one successful whack.
REQ-008 best1, best0  in  4 each  current high score (tens, units BCD) from the record block.
REQ-009 state  out  2  00 IDLE, 01 READY, 10 PLAY, 11 DONE.
REQ-010 time1, time0  out  4 each  remaining seconds, BCD tens/units.
REQ-011 score1, score0  out  4 each  current round score, BCD tens/units.
REQ-012 rec_we  out  1  one-cycle pulse instructing the record block to sample score1/score0.
REQ-013 new_best  out  1  high while in DONE if final score strictly exceeded best at round end.
REQ-014 mole_en  out  1  high exactly while state is PLAY.

Function
REQ-015 Tick: internal counter 0..TICK_DIV-1 runs in READY and PLAY only; tick asserted one cycle when counter = TICK_DIV-1, then counter wraps to 0.
REQ-016 Tick counter cleared to 0 on every state transition.
REQ-017 IDLE: start -> READY next cycle; time loaded with READY_SEC (time1=0), score cleared to 00.
REQ-018 READY: each tick decrements time by one; tick when time = 01 -> PLAY, time loaded with ROUND_SEC in BCD, score held at 00.
REQ-019 PLAY: each tick decrements time in BCD (units 0 -> 9 with tens borrow); tick when time = 01 -> DONE, time = 00.
REQ-020 PLAY: hit increments score in BCD (units 9 -> 0 with tens carry); score saturates at 99.
REQ-021 hit in any state other than PLAY is ignored; hit coincident with the final PLAY tick is counted and the incremented score is what is committed.
REQ-022 Entry to DONE: rec_we pulses for exactly the first DONE cycle; score held stable throughout DONE.
REQ-023 new_best set on DONE entry iff {score1,score0} > {best1,best0} (compare tens first, then units), using best values sampled in the last PLAY cycle; held until DONE exits.
REQ-024 DONE: start -> READY (same as REQ-017: score cleared, new_best cleared); otherwise remain.
REQ-025 start in READY or PLAY is ignored (no restart mid-round).
REQ-026 Time and score outputs are always valid BCD (each digit 0..9).
REQ-027 Latency: state, time, score outputs registered; change one cycle after the causing input or tick.

Reset
REQ-028 rst high at a rising edge forces state IDLE, time 00, score 00, rec_we 0, new_best 0, mole_en 0, tick counter 0, regardless of other inputs.
REQ-029 rst during READY/PLAY/DONE aborts the round with no rec_we pulse.
REQ-030 rst has priority over start and hit in the same cycle.

Verification (TICK_DIV=4, ROUND_SEC=12, READY_SEC=3)
REQ-031 rst, then start pulse -> state 01, time 03, score 00; after 3 ticks (12 cycles) state 10, time 12, mole_en 1.
REQ-032 In PLAY, 5 hits -> score 05; tick at time 10 -> time 09 (BCD borrow); hits while IDLE/READY/DONE -> score unchanged.
REQ-033 Round ends with score 07, best 05 -> state 11, time 00, rec_we single pulse on first DONE cycle, new_best 1.
REQ-034 Round ends with score 05, best 05 -> rec_we pulse, new_best 0; in DONE, start -> state 01, score 00, new_best 0.
REQ-035 Score at 99 plus 3 further hits -> score stays 99; score 09 plus hit -> 10.
REQ-036 rst asserted mid-PLAY (time 07, score 04) -> next cycle state 00, time 00, score 00, no rec_we pulse ever emitted.
